// File: rtl/nibble_add_seq.sv
// Sequencer for a W=4*NIBBLES-bit add on one shared external 4-bit adder,
// one nibble per clock, LSB first, carry held in a register between nibbles.
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      load;
    logic                      last;
    logic [NIBBLES-1:0][3:0]   a_reg;
    logic [NIBBLES-1:0][3:0]   b_reg;
    logic [NIBBLES-1:0][3:0]   work;
    logic                      carry;
    logic [IW-1:0]             idx;

    assign last = (idx == LAST_IDX);

    // State register; busy/done are flopped decodes of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= (state_next == S_DONE);
        end
    end

    // Next-state logic; DONE accepts a new start directly (no bubble).
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Adder drive: current nibble while running, quiet otherwise.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    // Datapath: operand capture, per-nibble accumulation, result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            work   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            idx   <= '0;
        end else if (state == S_RUN) begin
            work[idx] <= add_sum;
            carry     <= add_cout;
            if (last) begin
                idx    <= '0;
                result <= W'({add_sum, work[NIBBLES-2:0]});
                cout   <= add_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and random checks of nibble_add_seq with a 4-bit adder model wired
// to its add_* ports.
module tb_nibble_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_res;
    logic        model_cout;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External shared 4-bit ripple adder.
    always_comb {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] exp_res;
        logic        exp_cout;
        logic [15:0] exp_aseq;
        logic [3:0]  exp_cseq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation from IDLE; expects the DUT idle at the first negedge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] er, input logic ec, input bit seq_chk,
                         input logic [15:0] easeq, input logic [3:0] ecseq);
        logic [15:0] aseq;
        logic [3:0]  cseq;
        aseq = '0;
        cseq = '0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                op_a  = ~a;
                op_b  = ~b;
                cin   = ~c;
            end
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_result_stable", 32'(result), 32'(model_res));
            aseq = {aseq[11:0], add_a};
            cseq = {cseq[2:0], add_cin};
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        if (seq_chk) begin
            check("add_a_seq", 32'(aseq), 32'(easeq));
            check("add_cin_seq", 32'(cseq), 32'(ecseq));
        end
        model_res  = er;
        model_cout = ec;
    endtask

    initial begin
        logic [16:0] sums[10];
        logic [16:0] s;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        bit          saw_done;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h4321, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 4'b0111};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 4'b1111};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0000};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0008, 4'b0000};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 16'hF0F0, 4'b0111};
        vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'hFFF7, 4'b1111};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 16'hDCBA, 4'b0110};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        model_res  = '0;
        model_cout = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_res, vecs[i].exp_cout,
                  1'b1, vecs[i].exp_aseq, vecs[i].exp_cseq);
        end

        // start held 10 cycles with changing operands: accepts at cycles 0 and 5
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            check("hold_done", 32'(done), 32'((i == 5) || (i == 10)));
            check("hold_busy", 32'(busy), 32'(((i >= 1) && (i <= 4)) || ((i >= 6) && (i <= 9))));
            if (i == 5) check("hold_result0", {15'd0, cout, result}, 32'(sums[0]));
            if (i == 10) check("hold_result1", {15'd0, cout, result}, 32'(sums[5]));
            if (i < 10) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                sums[i] = 17'(ra) + 17'(rb) + 17'(rc);
                start = 1'b1;
                op_a  = ra;
                op_b  = rb;
                cin   = rc;
            end else begin
                start = 1'b0;
            end
        end
        model_res  = sums[5][15:0];
        model_cout = sums[5][16];

        // Reset mid-RUN after two nibbles
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'h9999;
        op_b  = 16'h7777;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_result_hold", 32'(result), 32'd0);
        model_res  = '0;
        model_cout = 1'b0;
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1, 16'h4321, 4'b0000);

        // Random operations against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            s  = 17'(ra) + 17'(rb) + 17'(rc);
            do_op(ra, rb, rc, s[15:0], s[16], 1'b0, 16'h0000, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
